// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction-fetch front end.
//   fetch_state_t : FSM encoding of the fetch unit (idle / request / hold)
//   WORD_W        : datapath word width
//   DEF_RESET_PC  : default PC loaded on reset
//   DEF_PC_INCR   : default byte increment per sequential instruction
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [WORD_W-1:0] DEF_PC_INCR  = 32'd4;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_redirect_sel.sv
// -----------------------------------------------------------------------------
// pc_redirect_sel
// Combinational priority select of the PC redirect target.
//   branch_taken  in  1   EX-stage branch resolved taken
//   branch_target in  32  branch target from the PC jump adder
//   jump_taken    in  1   ID-stage jump
//   jump_target   in  32  jump target address
//   redirect      out 1   any redirect this cycle
//   target        out 32  selected redirect address
// The branch wins over a simultaneous jump because it belongs to the older
// instruction; the jump behind it is on the wrong path anyway.
// -----------------------------------------------------------------------------
module pc_redirect_sel
    import mips_pkg::*;
(
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    input  logic              jump_taken,
    input  logic [WORD_W-1:0] jump_target,
    output logic              redirect,
    output logic [WORD_W-1:0] target
);

    always_comb begin
        redirect = branch_taken | jump_taken;
        target   = jump_target;
        if (branch_taken) begin
            target = branch_target;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Instruction-fetch front end: holds the PC, issues one instruction-memory
// request at a time over req/ack, and presents each fetched instruction plus
// its PC+PC_INCR to IF/ID under a valid/stall handshake. Branch and jump
// redirects are applied in every state, including while a request is in
// flight (the in-flight response is then squashed).
//   clock        in  1   system clock, rising edge
//   reset_n      in  1   asynchronous active-low reset
//   branchTaken  in  1   EX-stage branch taken pulse
//   addPCResult  in  32  branch target
//   jumpTaken    in  1   ID-stage jump pulse
//   jumpTarget   in  32  jump target
//   stall        in  1   IF/ID cannot accept this cycle
//   imemReq      out 1   instruction memory request
//   imemAddr     out 32  request address (= PC), stable while imemReq=1
//   imemAck      in  1   response pulse, imemData valid this cycle
//   imemData     in  32  instruction word
//   instrValid   out 1   instruction/incrPC valid to IF/ID
//   instruction  out 32  fetched instruction
//   incrPC       out 32  fetched instruction address + PC_INCR
//   pcCurrent    out 32  current PC register
// -----------------------------------------------------------------------------
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [WORD_W-1:0] PC_INCR  = DEF_PC_INCR
)(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              branchTaken,
    input  logic [WORD_W-1:0] addPCResult,
    input  logic              jumpTaken,
    input  logic [WORD_W-1:0] jumpTarget,
    input  logic              stall,
    output logic              imemReq,
    output logic [WORD_W-1:0] imemAddr,
    input  logic              imemAck,
    input  logic [WORD_W-1:0] imemData,
    output logic              instrValid,
    output logic [WORD_W-1:0] instruction,
    output logic [WORD_W-1:0] incrPC,
    output logic [WORD_W-1:0] pcCurrent
);

    fetch_state_t      state;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_next;   // deferred redirect target while squashing
    logic              squash;    // outstanding response belongs to a dead path
    logic              redirect;
    logic [WORD_W-1:0] target;
    logic [WORD_W-1:0] pc_inc;

    pc_redirect_sel u_redirect_sel (
        .branch_taken  (branchTaken),
        .branch_target (addPCResult),
        .jump_taken    (jumpTaken),
        .jump_target   (jumpTarget),
        .redirect      (redirect),
        .target        (target)
    );

    // Modulo-2^32 add: the top word of the address space wraps to zero.
    assign pc_inc    = pc + PC_INCR;
    assign imemAddr  = pc;
    assign pcCurrent = pc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FETCH_IDLE;
            pc          <= RESET_PC;
            pc_next     <= RESET_PC;
            squash      <= 1'b0;
            imemReq     <= 1'b0;
            instrValid  <= 1'b0;
            instruction <= '0;
            incrPC      <= '0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (redirect) begin
                        pc <= target;
                    end
                    state   <= FETCH_REQ;
                    imemReq <= 1'b1;
                end

                FETCH_REQ: begin
                    if (imemAck) begin
                        // A redirect arriving with the ack is newest and
                        // overrides any deferred target.
                        if (redirect) begin
                            pc     <= target;
                            squash <= 1'b0;
                        end else if (squash) begin
                            pc     <= pc_next;
                            squash <= 1'b0;
                        end else begin
                            instruction <= imemData;
                            incrPC      <= pc_inc;
                            pc          <= pc_inc;
                            state       <= FETCH_HOLD;
                            imemReq     <= 1'b0;
                            instrValid  <= 1'b1;
                        end
                    end else if (redirect) begin
                        // Request cannot be aborted: keep imemAddr stable and
                        // park the target until the response drains.
                        pc_next <= target;
                        squash  <= 1'b1;
                    end
                end

                FETCH_HOLD: begin
                    if (redirect) begin
                        pc         <= target;
                        instrValid <= 1'b0;
                        state      <= FETCH_REQ;
                        imemReq    <= 1'b1;
                    end else if (!stall) begin
                        instrValid <= 1'b0;
                        state      <= FETCH_REQ;
                        imemReq    <= 1'b1;
                    end
                end

                default: begin
                    state      <= FETCH_IDLE;
                    imemReq    <= 1'b0;
                    instrValid <= 1'b0;
                    squash     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        branchTaken;
    logic [31:0] addPCResult;
    logic        jumpTaken;
    logic [31:0] jumpTarget;
    logic        stall;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        instrValid;
    logic [31:0] instruction;
    logic [31:0] incrPC;
    logic [31:0] pcCurrent;

    int total = 0;
    int bad   = 0;

    pc_fetch_unit dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .branchTaken (branchTaken),
        .addPCResult (addPCResult),
        .jumpTaken   (jumpTaken),
        .jumpTarget  (jumpTarget),
        .stall       (stall),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemAck     (imemAck),
        .imemData    (imemData),
        .instrValid  (instrValid),
        .instruction (instruction),
        .incrPC      (incrPC),
        .pcCurrent   (pcCurrent)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expect a pending request at addr, answer it, expect the held instruction.
    task automatic fetch_ack(input string tag, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] incr);
        chk({tag, "_req"},  imemReq, 1'b1);
        chk({tag, "_addr"}, imemAddr, addr);
        imemAck  = 1'b1;
        imemData = data;
        step();
        imemAck  = 1'b0;
        imemData = 32'hDEAD_BEEF;
        chk({tag, "_vld"},   instrValid, 1'b1);
        chk({tag, "_instr"}, instruction, data);
        chk({tag, "_incr"},  incrPC, incr);
        chk({tag, "_reqlo"}, imemReq, 1'b0);
    endtask

    initial begin
        reset_n     = 1'b0;
        branchTaken = 1'b0;
        addPCResult = '0;
        jumpTaken   = 1'b0;
        jumpTarget  = '0;
        stall       = 1'b0;
        imemAck     = 1'b0;
        imemData    = '0;

        // Reset state
        #1;
        chk("rst_req",   imemReq, 1'b0);
        chk("rst_vld",   instrValid, 1'b0);
        chk("rst_pc",    pcCurrent, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_incr",  incrPC, 32'h0);
        step();
        chk("rst_hold_req", imemReq, 1'b0);
        reset_n = 1'b1;
        step();

        // Sequential fetches 0,4,8
        fetch_ack("seq0", 32'h0, 32'h1111_0000, 32'h4);
        step();
        chk("seq0_vld_drop", instrValid, 1'b0);
        fetch_ack("seq1", 32'h4, 32'h1111_0004, 32'h8);
        step();
        fetch_ack("seq2", 32'h8, 32'h1111_0008, 32'hC);
        step();

        // Stall holds the instruction for 4 cycles total
        fetch_ack("stl", 32'hC, 32'h2008_0005, 32'h10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stl_vld",   instrValid, 1'b1);
            chk("stl_instr", instruction, 32'h2008_0005);
            chk("stl_incr",  incrPC, 32'h10);
            chk("stl_req",   imemReq, 1'b0);
        end
        stall = 1'b0;
        step();
        chk("stl_rel_vld",  instrValid, 1'b0);
        chk("stl_rel_req",  imemReq, 1'b1);
        chk("stl_rel_addr", imemAddr, 32'h10);

        // Branch while request outstanding: address stable, response squashed
        step();
        branchTaken = 1'b1;
        addPCResult = 32'h0000_0040;
        step();
        branchTaken = 1'b0;
        chk("sq_addr1", imemAddr, 32'h10);
        chk("sq_req1",  imemReq, 1'b1);
        step();
        chk("sq_addr2", imemAddr, 32'h10);
        imemAck  = 1'b1;
        imemData = 32'hBAD0_BAD0;
        step();
        imemAck = 1'b0;
        chk("sq_vld",  instrValid, 1'b0);
        chk("sq_pc",   pcCurrent, 32'h40);
        fetch_ack("sq_tgt", 32'h40, 32'h3333_0040, 32'h44);

        // Branch and jump together in HOLD (with stall): branch wins
        stall       = 1'b1;
        branchTaken = 1'b1;
        addPCResult = 32'h0000_0100;
        jumpTaken   = 1'b1;
        jumpTarget  = 32'h0000_0200;
        step();
        branchTaken = 1'b0;
        jumpTaken   = 1'b0;
        stall       = 1'b0;
        chk("pri_vld",  instrValid, 1'b0);
        chk("pri_req",  imemReq, 1'b1);
        chk("pri_addr", imemAddr, 32'h100);

        // Jump together with ack: data discarded, next address is the target
        jumpTaken  = 1'b1;
        jumpTarget = 32'hFFFF_FFFC;
        imemAck    = 1'b1;
        imemData   = 32'hBAD1_BAD1;
        step();
        jumpTaken = 1'b0;
        imemAck   = 1'b0;
        chk("rda_vld",  instrValid, 1'b0);
        chk("rda_req",  imemReq, 1'b1);
        chk("rda_addr", imemAddr, 32'hFFFF_FFFC);

        // Wrap-around at the top of the address space
        fetch_ack("wrap", 32'hFFFF_FFFC, 32'h4444_FFFC, 32'h0);
        step();
        chk("wrap_next", imemAddr, 32'h0);

        // Two redirects during one outstanding request: latest wins
        branchTaken = 1'b1;
        addPCResult = 32'h80;
        step();
        branchTaken = 1'b0;
        jumpTaken   = 1'b1;
        jumpTarget  = 32'h90;
        step();
        jumpTaken = 1'b0;
        chk("dbl_addr_stable", imemAddr, 32'h0);
        imemAck = 1'b1;
        step();
        imemAck = 1'b0;
        chk("dbl_vld",  instrValid, 1'b0);
        chk("dbl_addr", imemAddr, 32'h90);

        // Asynchronous reset in the middle of a request
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_req", imemReq, 1'b0);
        chk("arst_vld", instrValid, 1'b0);
        chk("arst_pc",  pcCurrent, 32'h0);
        step();
        reset_n = 1'b1;
        step();
        fetch_ack("arst_restart", 32'h0, 32'h5555_0000, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch front end; the consumer of the EX-stage branch target (addPCResult) and the producer of incrPC.
- Holds the architectural PC and issues one instruction-memory request at a time over a req/ack handshake.
- Presents each fetched instruction plus its PC+4 to the IF/ID register with a valid/stall handshake.
- Applies branch/jump redirects, including redirects that arrive while a memory request is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_INCR, 4, byte increment per sequential instruction

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
branchTaken  in  1  EX-stage branch resolved taken (1-cycle pulse)
addPCResult  in  32  branch target from PC jump adder
jumpTaken  in  1  ID-stage jump (1-cycle pulse)
jumpTarget  in  32  jump target address
stall  in  1  IF/ID cannot accept this cycle
imemReq  out  1  instruction memory request
imemAddr  out  32  request address; stable while imemReq=1
imemAck  in  1  1-cycle pulse; imemData valid this cycle
imemData  in  32  instruction word
instrValid  out  1  instruction/incrPC valid to IF/ID
instruction  out  32  fetched instruction
incrPC  out  32  address of fetched instruction + PC_INCR
pcCurrent  out  32  current PC register

Behaviour:
- Reset, asynchronous on reset_n low, any state: pc=RESET_PC, state=IDLE, imemReq=0, instrValid=0, instruction=0, incrPC=0, squash=0. An outstanding memory request is abandoned; memory must tolerate this.
- States: IDLE, REQ, HOLD. imemReq=1 only in REQ; instrValid=1 only in HOLD; imemAddr=pc.
- IDLE: first rising edge with reset_n high moves to REQ.
- REQ, imemAck=1, squash=0, no redirect:
  - instruction<=imemData, incrPC<=pc+PC_INCR, pc<=pc+PC_INCR.
  - Move to HOLD; instrValid rises the cycle after the ack edge.
- REQ, no ack: stay; imemAddr unchanged.
- HOLD: transfer occurs on an edge with stall=0; go to REQ, instrValid<=0. stall=1 holds all outputs.
- Redirect: redirect target = addPCResult if branchTaken, else jumpTarget. branchTaken wins when both are asserted (older instruction).
  - Redirect in HOLD: held instruction dropped, whether or not stall=1. pc<=target, instrValid<=0, go to REQ.
  - Redirect in REQ with ack on the same edge: imemData discarded, pc<=target, stay in REQ. The next cycle's imemAddr is the target.
  - Redirect in REQ without ack: the request is not abortable and imemAddr stays stable. pc_next<=target, squash<=1.
  - When the squashed ack arrives: data discarded, pc<=pc_next, squash<=0, stay in REQ.
  - A second redirect while squash=1 overwrites pc_next; the latest redirect wins.
  - Redirect in IDLE: pc<=target.
- Arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. No alignment check; targets are used as given.
- Throughput: at most 1 instruction per 2 cycles (zero-wait memory). Latency: ack edge to instrValid high = 1 cycle.

Decomposition:
- Shared package (mips_pkg): FETCH_IDLE/FETCH_REQ/FETCH_HOLD state encodings, RESET_PC default, PC_INCR default, 32-bit word width constant.
- One natural sub-module, pc_redirect_sel: combinational priority select of redirect target and redirect-valid from branchTaken/jumpTaken.
- The FSM, PC register and output register stay in pc_fetch_unit.

Test Plan:
- Reset release, ack 1 cycle after each req, stall=0 → imemAddr sequence 0,4,8; instrValid pulses carrying incrPC 4,8,12; instruction equals supplied data.
- HOLD with instruction 32'h2008_0005, stall=1 for 3 cycles → instrValid and instruction stable for 4 cycles, imemReq=0. After stall drops, the next imemAddr is the following PC.
- Ack delayed 3 cycles, branchTaken with addPCResult=32'h0000_0040 in cycle 1 of wait → imemAddr stays at old PC until ack, data discarded, no instrValid. Next imemAddr=0x40; its instruction gives incrPC=0x44.
- branchTaken (0x100) and jumpTaken (0x200) on the same edge in HOLD → held instruction dropped, next imemAddr=0x100.
- PC=32'hFFFF_FFFC, ack → incrPC=0, next imemAddr=0.
- reset_n low mid-REQ asynchronously → imemReq and instrValid drop immediately, pcCurrent=RESET_PC; fetch restarts from RESET_PC after release.
